// File: rtl/address_queue_latch.sv
// Address queue latch: a small FIFO of outstanding memory-cycle addresses. The
// head entry drives a registered addr_out. While the queue is empty, addr_out
// either follows a valid addr_in or holds its last value.
module address_queue_latch #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TRANSPARENT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_WIDTH-1:0]      addr_in,
  input  logic                       addr_valid,
  input  logic                       mem_cycle_start,
  input  logic                       mem_cycle_end,
  input  logic                       clear_err,
  output logic [ADDR_WIDTH-1:0]      addr_out,
  output logic                       addr_latched,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [ADDR_WIDTH-1:0] r_addr_out;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_empty;
  logic                  w_is_full;
  logic                  w_push_req;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf_evt;
  logic                  w_udf_evt;
  logic [PTR_W-1:0]      w_head_next;
  logic [CNT_W-1:0]      w_count_next;
  logic                  w_fwd;
  logic [ADDR_WIDTH-1:0] w_addr_out_next;

  // Decode push/pop/error events and the next-state values from the current state
  always_comb begin
    w_empty         = (r_count == '0);
    w_is_full       = (r_count == CNT_W'(DEPTH));
    w_push_req      = mem_cycle_start && addr_valid;
    w_pop           = mem_cycle_end && !w_empty;
    w_push          = w_push_req && (!w_is_full || w_pop);
    w_ovf_evt       = w_push_req && !w_push;
    w_udf_evt       = mem_cycle_end && w_empty;
    w_head_next     = w_pop ? r_head + PTR_W'(1) : r_head;
    w_count_next    = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_W'(1);
    end
    // The new head is the entry being written this edge when nothing older survives
    w_fwd           = w_push && (r_count == CNT_W'(w_pop));
    w_addr_out_next = r_addr_out;
    if (w_count_next != '0) begin
      w_addr_out_next = w_fwd ? addr_in : r_mem[w_head_next];
    end else if ((TRANSPARENT != 0) && addr_valid) begin
      w_addr_out_next = addr_in;
    end
  end

  // Queue storage; contents are don't-care after reset so no reset term
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= addr_in;
    end
  end

  // Pointers, occupancy, output address and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_addr_out <= '0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      r_head     <= w_head_next;
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      r_count    <= w_count_next;
      r_addr_out <= w_addr_out_next;
      if (w_ovf_evt) begin
        r_ovf <= 1'b1;
      end else if (clear_err) begin
        r_ovf <= 1'b0;
      end
      if (w_udf_evt) begin
        r_udf <= 1'b1;
      end else if (clear_err) begin
        r_udf <= 1'b0;
      end
    end
  end

  assign addr_out      = r_addr_out;
  assign count         = r_count;
  assign addr_latched  = (r_count != '0);
  assign full          = (r_count == CNT_W'(DEPTH));
  assign overflow_err  = r_ovf;
  assign underflow_err = r_udf;

endmodule

// File: tb/tb_address_queue_latch.sv
// Bench for address_queue_latch: directed scenarios plus random traffic against
// a queue-based reference model.
module tb_address_queue_latch;

  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr_in;
  logic          addr_valid;
  logic          mem_cycle_start;
  logic          mem_cycle_end;
  logic          clear_err;
  logic [AW-1:0] addr_out;
  logic          addr_latched;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow_err;
  logic          underflow_err;

  int n_checks;
  int n_fail;

  // Reference model state
  logic [AW-1:0] m_q[$];
  logic [AW-1:0] m_out;
  bit            m_ovf;
  bit            m_udf;

  address_queue_latch #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .TRANSPARENT(1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .addr_in        (addr_in),
    .addr_valid     (addr_valid),
    .mem_cycle_start(mem_cycle_start),
    .mem_cycle_end  (mem_cycle_end),
    .clear_err      (clear_err),
    .addr_out       (addr_out),
    .addr_latched   (addr_latched),
    .count          (count),
    .full           (full),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr_out"}, 32'(addr_out), 32'(m_out));
    check({tag, ".count"}, 32'(count), 32'(m_q.size()));
    check({tag, ".latched"}, 32'(addr_latched), 32'(m_q.size() > 0));
    check({tag, ".full"}, 32'(full), 32'(m_q.size() == DEPTH));
    check({tag, ".ovf"}, 32'(overflow_err), 32'(m_ovf));
    check({tag, ".udf"}, 32'(underflow_err), 32'(m_udf));
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Drive one edge worth of inputs, advance the model, then compare after the edge
  task automatic step(input bit s, input bit e, input bit v, input logic [AW-1:0] a,
                      input bit c, input string tag);
    bit pop, push_req, push, ovf_evt, udf_evt;
    mem_cycle_start = s;
    mem_cycle_end   = e;
    addr_valid      = v;
    addr_in         = a;
    clear_err       = c;
    pop      = e && (m_q.size() > 0);
    push_req = s && v;
    push     = push_req && ((m_q.size() < DEPTH) || pop);
    ovf_evt  = push_req && !push;
    udf_evt  = e && (m_q.size() == 0);
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(a);
    if (m_q.size() > 0) m_out = m_q[0];
    else if (v)         m_out = a;
    if (ovf_evt)  m_ovf = 1'b1;
    else if (c)   m_ovf = 1'b0;
    if (udf_evt)  m_udf = 1'b1;
    else if (c)   m_udf = 1'b0;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Pulse reset between edges and verify outputs clear without waiting for a clock
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    addr_in         = '0;
    addr_valid      = 1'b0;
    mem_cycle_start = 1'b0;
    mem_cycle_end   = 1'b0;
    clear_err       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Idle transparency
    step(0, 0, 1, 16'hA000, 0, "transp0");
    check("transp0.val", 32'(addr_out), 32'h0000_A000);
    step(0, 0, 1, 16'hB000, 0, "transp1");
    check("transp1.val", 32'(addr_out), 32'h0000_B000);

    // Hold while latched, then release on end
    step(1, 0, 1, 16'hB000, 0, "hold_push");
    step(0, 0, 1, 16'hC000, 0, "hold_c");
    step(0, 0, 1, 16'hD000, 0, "hold_d");
    check("hold.val", 32'(addr_out), 32'h0000_B000);
    step(0, 1, 1, 16'hD000, 0, "hold_end");
    step(0, 0, 1, 16'hD100, 0, "hold_track");
    check("hold_track.val", 32'(addr_out), 32'h0000_D100);

    // Fill, overflow, ordered drain
    for (int i = 0; i < 4; i++) step(1, 0, 1, AW'(16'h1000 + i * 16'h100), 0, "fill");
    check("fill.full", 32'(full), 32'd1);
    check("fill.count", 32'(count), 32'd4);
    step(1, 0, 1, 16'h1400, 0, "ovf_push");
    check("ovf.flag", 32'(overflow_err), 32'd1);
    step(0, 1, 1, 16'hEEEE, 0, "drain0");
    check("drain0.val", 32'(addr_out), 32'h0000_1100);
    for (int i = 1; i < 4; i++) step(0, 1, 1, 16'hEEEE, 0, "drain");
    check("drain.transp", 32'(addr_out), 32'h0000_EEEE);

    // Simultaneous push/pop when full, underflow, clear
    step(0, 0, 0, 16'h0, 1, "clr_pre");
    for (int i = 0; i < 4; i++) step(1, 0, 1, AW'(16'h5000 + i), 0, "refill");
    step(1, 1, 1, 16'h2000, 0, "simul");
    check("simul.count", 32'(count), 32'd4);
    check("simul.ovf", 32'(overflow_err), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0, 0, "simul_drain");
    check("simul.last", 32'(addr_out), 32'h0000_2000);
    step(0, 1, 0, 16'h0, 0, "underflow");
    check("udf.flag", 32'(underflow_err), 32'd1);
    step(1, 1, 1, 16'h2100, 0, "udf_push");
    step(0, 1, 0, 16'h0, 1, "clr_pop");
    step(0, 0, 0, 16'h0, 1, "clr");
    check("clr.udf", 32'(underflow_err), 32'd0);

    // Invalid starts are ignored
    step(1, 0, 0, 16'hF000, 0, "inv0");
    step(1, 0, 0, 16'hF010, 0, "inv1");
    step(1, 0, 0, 16'hF020, 0, "inv2");
    step(0, 0, 1, 16'hF020, 0, "inv_valid");
    check("inv.val", 32'(addr_out), 32'h0000_F020);

    // Reset in the middle of traffic
    for (int i = 0; i < 3; i++) step(1, 0, 1, AW'(16'h7000 + i), 0, "pre_rst");
    async_reset("mid_rst");
    step(1, 0, 1, 16'h3000, 0, "post_rst");
    check("post_rst.val", 32'(addr_out), 32'h0000_3000);
    check("post_rst.count", 32'(count), 32'd1);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 80, AW'($urandom), $urandom_range(0, 99) < 5, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/address_queue_latch.md
ADDRESS_QUEUE_LATCH -- requirements
Module: address_queue_latch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: width of address path.
REQ-002 SHALL have parameter DEPTH, default 4: outstanding memory cycles held; power of two, >= 2.
REQ-003 SHALL have parameter TRANSPARENT, default 1: 1 = addr_out follows addr_in while idle; 0 = addr_out holds while idle.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port addr_in  input  ADDR_WIDTH  candidate address.
REQ-007 SHALL have port addr_valid  input  1  addr_in qualifies for capture and transparency.
REQ-008 SHALL have port mem_cycle_start  input  1  start request; push addr_in.
REQ-009 SHALL have port mem_cycle_end  input  1  end request; retire oldest cycle.
REQ-010 SHALL have port clear_err  input  1  clears sticky error flags.
REQ-011 SHALL have port addr_out  output  ADDR_WIDTH  registered address presented to memory.
REQ-012 SHALL have port addr_latched  output  1  high when count > 0.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  outstanding cycles, 0..DEPTH.
REQ-014 SHALL have port full  output  1  high when count == DEPTH.
REQ-015 SHALL have port overflow_err  output  1  sticky; start dropped while full.
REQ-016 SHALL have port underflow_err  output  1  sticky; end seen while empty.

Function
REQ-017 Push SHALL occur on an edge with mem_cycle_start=1, addr_valid=1, and (count < DEPTH or pop on the same edge); addr_in written at tail, tail pointer +1 mod DEPTH.
REQ-018 Pop SHALL occur on an edge with mem_cycle_end=1 and count > 0; head pointer +1 mod DEPTH.
REQ-019 mem_cycle_start with addr_valid=0 SHALL be ignored, no error.
REQ-020 Push and pop on the same edge with count > 0 SHALL both occur; count unchanged; legal when full.
REQ-021 mem_cycle_end with count == 0 SHALL be ignored and set underflow_err, even with a simultaneous push (push still occurs).
REQ-022 Push attempt with count == DEPTH and no pop SHALL be dropped and set overflow_err; stored entries unchanged.
REQ-023 count SHALL be +1 on push-only, -1 on pop-only, else unchanged; never exceeds DEPTH or goes below 0.
REQ-024 addr_out next value SHALL be: post-edge head entry if post-edge count > 0; else addr_in if TRANSPARENT=1 and addr_valid=1; else hold.
REQ-025 Push into empty queue SHALL present the pushed address on addr_out at that same edge (1-cycle latency from input to output).
REQ-026 addr_out SHALL remain stable while count > 0 and no pop occurs, regardless of addr_in/addr_valid.
REQ-027 Pointers SHALL wrap modulo DEPTH without loss of order (strict FIFO).
REQ-028 clear_err SHALL clear both error flags on the next edge; a same-edge error event SHALL win over clear_err.
REQ-029 addr_latched and full SHALL be decoded from registered count, no combinational path from inputs.

Reset
REQ-030 rst_n=0 SHALL immediately force count=0, pointers=0, addr_out=0, addr_latched=0, full=0, overflow_err=0, underflow_err=0.
REQ-031 Reset asserted mid-cycle SHALL discard all outstanding entries; storage contents need not be cleared.
REQ-032 First edge after rst_n rises SHALL behave per REQ-017..REQ-028 with no extra wait state.

Verification (ADDR_WIDTH=16, DEPTH=4, TRANSPARENT=1)
REQ-033 Idle transparency: addr_valid=1, addr_in 0xA000 then 0xB000 -> addr_out 0xA000 then 0xB000 one edge later each; addr_latched=0.
REQ-034 Hold: push 0xB000, then addr_in 0xC000, 0xD000 -> addr_out stays 0xB000, count=1; end -> count=0, addr_out tracks addr_in next edge.
REQ-035 Fill/overflow/order: push 0x1000,0x1100,0x1200,0x1300 -> full=1, count=4; push 0x1400 -> dropped, overflow_err=1; four pops -> addr_out 0x1100,0x1200,0x1300, then transparent; order preserved.
REQ-036 Simultaneous: count=4, start+end with addr_in 0x2000 -> count=4, overflow_err=0, 0x2000 emerges last; count=0 end -> underflow_err=1; clear_err -> both flags 0.
REQ-037 Invalid: addr_valid=0, addr_in 0xF000..0xF020, start pulses -> no push, addr_out holds; addr_valid=1 -> addr_out 0xF020 next edge.
REQ-038 Reset mid-operation: count=3, rst_n low asynchronously between edges -> all outputs 0 immediately; after release, push 0x3000 -> addr_out 0x3000, count=1.
